key_event: RTL

KEY_EVENT -- requirements
Module: key_event

---
 rtl/key_event_pkg.sv | 19 +
 rtl/key_edge_detect.sv | 28 ++
 rtl/key_event.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/key_event_pkg.sv
// key_event_pkg: state encodings and default parameter constants for key_event.
`default_nettype none

package key_event_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } key_state_e;

  localparam int DEF_LONG_PRESS_LENGTH    = 16;
  localparam int DEF_LONG_PRESS_BIT_WIDTH = 4;
  localparam int DEF_REPEAT_PERIOD        = 4;
  localparam int DEF_REPEAT_BIT_WIDTH     = 2;

endpackage

`default_nettype wire

// File: rtl/key_edge_detect.sv
// key_edge_detect: registers the previous debounced level (reset 1, key up)
// and produces fall (press) / rise (release) strobes for the key FSM.
`default_nettype none

module key_edge_detect (
  input  logic clk_db,
  input  logic reset_n,
  input  logic level_n_i,
  output logic fall_o,
  output logic rise_o
);

  logic level_q;

  always_ff @(posedge clk_db) begin
    if (!reset_n) begin
      level_q <= 1'b1;
    end else begin
      level_q <= level_n_i;
    end
  end

  assign fall_o = level_q & ~level_n_i;
  assign rise_o = ~level_q & level_n_i;

endmodule

`default_nettype wire

// File: rtl/key_event.sv
// key_event: press / release / long-press / auto-repeat pulse generator for a
// debounced active-low key. Auto-repeat is built in only when KEY_EVENT_REPEAT_EN is defined.
`default_nettype none

module key_event
  import key_event_pkg::*;
#(
  parameter int LONG_PRESS_LENGTH    = DEF_LONG_PRESS_LENGTH,
  parameter int LONG_PRESS_BIT_WIDTH = DEF_LONG_PRESS_BIT_WIDTH,
  parameter int REPEAT_PERIOD        = DEF_REPEAT_PERIOD,
  parameter int REPEAT_BIT_WIDTH     = DEF_REPEAT_BIT_WIDTH
) (
  input  logic clk_db,
  input  logic reset_n,
  input  logic signal_debounced_n,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_repeat,
  output logic key_held
);

  if ((LONG_PRESS_LENGTH < 2) || ((2 ** LONG_PRESS_BIT_WIDTH) < LONG_PRESS_LENGTH) ||
      (REPEAT_PERIOD < 1) || ((2 ** REPEAT_BIT_WIDTH) < REPEAT_PERIOD)) begin : g_bad_params
    $error("key_event: illegal parameter combination");
  end

  // The hold count holds samples-so-far; reaching LONG_PRESS_LENGTH is detected
  // one step early so the count always fits in LONG_PRESS_BIT_WIDTH bits.
  localparam logic [LONG_PRESS_BIT_WIDTH-1:0] HOLD_LAST =
    LONG_PRESS_BIT_WIDTH'(LONG_PRESS_LENGTH - 1);
  localparam logic [LONG_PRESS_BIT_WIDTH-1:0] HOLD_ONE = LONG_PRESS_BIT_WIDTH'(1);

  logic       fall;
  logic       rise;
  key_state_e state_q;
  logic [LONG_PRESS_BIT_WIDTH-1:0] hold_q;
  logic       press_q;
  logic       release_q;
  logic       long_q;
  logic       held_q;

`ifdef KEY_EVENT_REPEAT_EN
  localparam logic [REPEAT_BIT_WIDTH-1:0] REP_LAST = REPEAT_BIT_WIDTH'(REPEAT_PERIOD - 1);
  localparam logic [REPEAT_BIT_WIDTH-1:0] REP_ONE  = REPEAT_BIT_WIDTH'(1);
  logic [REPEAT_BIT_WIDTH-1:0] rep_q;
  logic                        repeat_q;
`endif

  key_edge_detect u_edge (
    .clk_db    (clk_db),
    .reset_n   (reset_n),
    .level_n_i (signal_debounced_n),
    .fall_o    (fall),
    .rise_o    (rise)
  );

  always_ff @(posedge clk_db) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      held_q    <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
      rep_q     <= '0;
      repeat_q  <= 1'b0;
`endif
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
      repeat_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (fall) begin
            press_q <= 1'b1;
            held_q  <= 1'b1;
            hold_q  <= HOLD_ONE;
            state_q <= PRESSED;
          end
        end

        PRESSED: begin
          if (rise) begin
            release_q <= 1'b1;
            held_q    <= 1'b0;
            hold_q    <= '0;
            state_q   <= IDLE;
          end else if (hold_q == HOLD_LAST) begin
            long_q  <= 1'b1;
            state_q <= LONG;
`ifdef KEY_EVENT_REPEAT_EN
            rep_q   <= '0;
`endif
          end else begin
            hold_q <= hold_q + HOLD_ONE;
          end
        end

        LONG: begin
          // hold_q stays saturated here, so key_long cannot fire again
          if (rise) begin
            release_q <= 1'b1;
            held_q    <= 1'b0;
            hold_q    <= '0;
            state_q   <= IDLE;
`ifdef KEY_EVENT_REPEAT_EN
            rep_q     <= '0;
`endif
          end else begin
`ifdef KEY_EVENT_REPEAT_EN
            if (rep_q == REP_LAST) begin
              repeat_q <= 1'b1;
              rep_q    <= '0;
            end else begin
              rep_q <= rep_q + REP_ONE;
            end
`endif
          end
        end

        default: begin
          state_q <= IDLE;
          held_q  <= 1'b0;
          hold_q  <= '0;
        end
      endcase
    end
  end

  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;
  assign key_held    = held_q;
`ifdef KEY_EVENT_REPEAT_EN
  assign key_repeat  = repeat_q;
`else
  assign key_repeat  = 1'b0;
`endif

endmodule

`default_nettype wire
